// File: rtl/bram_arb_if.sv
// Requester-side bus of the BRAM arbiter: per-requester request slices in,
// one-hot grant/ready plus the shared read data out.
interface bram_arb_if #(
  parameter int NREQ = 2,
  parameter int AW   = 1,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req_i;
  logic [NREQ-1:0]    we_i;
  logic [NREQ-1:0]    lock_i;
  logic [NREQ*AW-1:0] addr_i;
  logic [NREQ*DW-1:0] data_i;
  logic [NREQ-1:0]    gnt_o;
  logic [NREQ-1:0]    rdy_o;
  logic [DW-1:0]      data_o;

  modport master (
    output req_i, we_i, lock_i, addr_i, data_i,
    input  gnt_o, rdy_o, data_o
  );

  modport slave (
    input  req_i, we_i, lock_i, addr_i, data_i,
    output gnt_o, rdy_o, data_o
  );
endinterface

// File: rtl/bram_arb.sv
// Round-robin arbiter sharing one single-clock BRAM port between NREQ requesters,
// with per-requester lock for RMW and tagged one-cycle read return.
module bram_arb #(
  parameter int NREQ = 2,
  parameter int SZ   = 2,
  parameter int DW   = 32,
  localparam int AW  = (SZ > 1) ? $clog2(SZ) : 1,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  bram_arb_if.slave     bus,
  output logic          bram_en_o,
  output logic          bram_we_o,
  output logic [AW-1:0] bram_addr_o,
  output logic [DW-1:0] bram_wdat_o,
  input  logic [DW-1:0] bram_rdat_i
);

  logic [IW-1:0]   rr;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   ptag;
  logic [IW-1:0]   win;
  logic            locked;
  logic            pend;
  logic            win_vld;
  logic [NREQ-1:0] cand;
  logic [AW-1:0]   addr_arr [NREQ];
  logic [DW-1:0]   wdat_arr [NREQ];

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] k);
    return (int'(k) == NREQ - 1) ? '0 : k + IW'(1);
  endfunction

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      addr_arr[k] = bus.addr_i[k*AW +: AW];
      wdat_arr[k] = bus.data_i[k*DW +: DW];
    end
  end

  // Search upward from rr with wrap; while locked only the owner may compete.
  always_comb begin
    int j;
    // NOTE: every signal assigned here gets a default before any branch, so no latch is inferred.
    j       = 0;
    win_vld = 1'b0;
    win     = '0;
    cand    = locked ? (bus.req_i & (NREQ'(1) << owner)) : bus.req_i;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(rr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!win_vld && cand[j]) begin
        win_vld = 1'b1;
        win     = IW'(j);
      end
    end
  end

  // With no winner, win stays 0 so address/data sit on requester 0's slice.
  always_comb begin
    bus.gnt_o   = '0;
    bus.rdy_o   = '0;
    bus.data_o  = '0;
    bram_en_o   = 1'b0;
    bram_we_o   = 1'b0;
    bram_addr_o = addr_arr[win];
    bram_wdat_o = wdat_arr[win];
    if (!rst_i) begin
      if (win_vld) begin
        bus.gnt_o = NREQ'(1) << win;
        bram_en_o = 1'b1;
        bram_we_o = bus.we_i[win];
      end
      if (pend) begin
        bus.rdy_o  = NREQ'(1) << ptag;
        bus.data_o = bram_rdat_i;
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr     <= '0;
      locked <= 1'b0;
      owner  <= '0;
      pend   <= 1'b0;
      ptag   <= '0;
    end else begin
      pend <= win_vld && !bus.we_i[win];
      if (win_vld && !bus.we_i[win]) ptag <= win;
      if (locked) begin
        // Release edge: the owner's last grant still counts, rr then moves past it.
        if (!bus.lock_i[owner]) begin
          locked <= 1'b0;
          rr     <= nxt(owner);
        end
      end else if (win_vld) begin
        rr <= nxt(win);
        if (bus.lock_i[win]) begin
          locked <= 1'b1;
          owner  <= win;
        end
      end
    end
  end

endmodule

// File: tb/tb_bram_arb.sv
// Self-checking bench for bram_arb: directed scenarios followed by constrained-random
// traffic, all compared against a transaction-level model of arbitration and memory.
module tb_bram_arb;
  localparam int NREQ = 2;
  localparam int SZ   = 16;
  localparam int DW   = 32;
  localparam int AW   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bram_arb_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  logic          bram_en;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_wdat;
  logic [DW-1:0] bram_rdat;

  bram_arb #(.NREQ(NREQ), .SZ(SZ), .DW(DW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bus        (bus),
    .bram_en_o  (bram_en),
    .bram_we_o  (bram_we),
    .bram_addr_o(bram_addr),
    .bram_wdat_o(bram_wdat),
    .bram_rdat_i(bram_rdat)
  );

  // Read-first single-port BRAM.
  logic [DW-1:0] mem [SZ];
  always @(posedge clk) begin
    if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_wdat;
      bram_rdat <= mem[bram_addr];
    end
  end

  // Transaction-level reference state.
  logic [DW-1:0] ref_mem [SZ];
  logic [DW-1:0] pre [SZ];
  int            m_rr, m_owner, m_ptag, m_found, last_found;
  bit            m_locked, m_pend;
  logic [DW-1:0] m_pdata;
  int            errors = 0;
  int            checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int k, input bit r, input bit w, input bit l,
                       input int a, input logic [DW-1:0] d);
    bus.req_i[k]              = r;
    bus.we_i[k]               = w;
    bus.lock_i[k]             = l;
    bus.addr_i[k*AW +: AW]    = AW'(a);
    bus.data_i[k*DW +: DW]    = d;
  endtask

  task automatic clear_all();
    for (int k = 0; k < NREQ; k++) drive(k, 1'b0, 1'b0, 1'b0, 0, '0);
  endtask

  // Mid-cycle: decide the winner from the rules and compare every output.
  task automatic sample();
    logic [NREQ-1:0] eg;
    logic [NREQ-1:0] er;
    bit              ewe;
    @(negedge clk);
    m_found = -1;
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) begin
        int k;
        k = (m_rr + i) % NREQ;
        if (m_found < 0 && bus.req_i[k] && (!m_locked || k == m_owner)) m_found = k;
      end
    end
    eg  = '0;
    ewe = 1'b0;
    if (m_found >= 0) begin
      eg[m_found] = 1'b1;
      ewe         = bus.we_i[m_found];
    end
    check("gnt", bus.gnt_o, eg);
    check("bram_en", bram_en, m_found >= 0);
    check("bram_we", bram_we, ewe);
    if (m_found >= 0) begin
      check("bram_addr", bram_addr, bus.addr_i[m_found*AW +: AW]);
      if (ewe) check("bram_wdat", bram_wdat, bus.data_i[m_found*DW +: DW]);
    end
    er = '0;
    if (!rst && m_pend) er[m_ptag] = 1'b1;
    check("rdy", bus.rdy_o, er);
    if (rst) check("data_rst", bus.data_o, '0);
    else if (m_pend) check("rdata", bus.data_o, m_pdata);
  endtask

  // At the edge: commit the model's transaction and lock/pointer rules.
  task automatic tick();
    int a;
    @(posedge clk);
    if (rst) begin
      m_rr = 0; m_locked = 1'b0; m_owner = 0; m_pend = 1'b0; m_ptag = 0;
    end else begin
      m_pend = 1'b0;
      if (m_found >= 0) begin
        a = int'(bus.addr_i[m_found*AW +: AW]);
        if (bus.we_i[m_found]) ref_mem[a] = bus.data_i[m_found*DW +: DW];
        else begin
          m_pend  = 1'b1;
          m_ptag  = m_found;
          m_pdata = ref_mem[a];
        end
      end
      if (m_locked) begin
        if (!bus.lock_i[m_owner]) begin
          m_locked = 1'b0;
          m_rr     = (m_owner + 1) % NREQ;
        end
      end else if (m_found >= 0) begin
        m_rr = (m_found + 1) % NREQ;
        if (bus.lock_i[m_found]) begin
          m_locked = 1'b1;
          m_owner  = m_found;
        end
      end
    end
    last_found = m_found;
    #1;
  endtask

  task automatic cyc();
    sample();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    clear_all();
    m_rr = 0; m_locked = 1'b0; m_owner = 0; m_pend = 1'b0; m_ptag = 0;
    m_found = -1; last_found = -1; m_pdata = '0;
    @(posedge clk);
    #1;

    // Reset state
    cyc();
    cyc();
    rst = 1'b0;

    // Preload through the arbiter, mem[5] gets the known pattern
    for (int a = 0; a < SZ; a++) begin
      pre[a] = (a == 5) ? 32'hA5A5_0005 : $urandom;
      drive(0, 1'b1, 1'b1, 1'b0, a, pre[a]);
      cyc();
    end
    clear_all();

    rst = 1'b1;
    cyc();
    rst = 1'b0;

    // Round-robin from reset: 0,1,0,1 with no idle cycles
    drive(0, 1'b1, 1'b0, 1'b0, 5, '0);
    drive(1, 1'b1, 1'b0, 1'b0, 9, '0);
    for (int i = 0; i < 8; i++) begin
      sample();
      check("rr_gnt", bus.gnt_o, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0) check("rr_rdy", bus.rdy_o, (i % 2 == 0) ? 2'b10 : 2'b01);
      tick();
    end
    clear_all();

    // Basic read
    drive(0, 1'b1, 1'b0, 1'b0, 5, '0);
    sample();
    check("basic_gnt", bus.gnt_o, 2'b01);
    tick();
    clear_all();
    sample();
    check("basic_rdy", bus.rdy_o, 2'b01);
    check("basic_data", bus.data_o, 32'hA5A5_0005);
    tick();

    // Write then read of the same address
    drive(1, 1'b1, 1'b1, 1'b0, 3, 32'hDEAD_BEEF);
    sample();
    check("wr_gnt", bus.gnt_o, 2'b10);
    tick();
    clear_all();
    drive(0, 1'b1, 1'b0, 1'b0, 3, '0);
    sample();
    check("wr_no_rdy", bus.rdy_o, 2'b00);
    tick();
    clear_all();
    sample();
    check("wr_rd_rdy", bus.rdy_o, 2'b01);
    check("wr_rd_data", bus.data_o, 32'hDEAD_BEEF);
    tick();

    // Move rr back to requester 0, then locked read-modify-write of addr 7
    drive(1, 1'b1, 1'b0, 1'b0, 2, '0);
    cyc();
    drive(0, 1'b1, 1'b0, 1'b1, 7, '0);
    drive(1, 1'b1, 1'b0, 1'b0, 2, '0);
    sample();
    check("lock_first", bus.gnt_o, 2'b01);
    tick();
    drive(0, 1'b0, 1'b0, 1'b1, 7, '0);
    sample();
    check("lock_owner_idle", bus.gnt_o, 2'b00);
    check("lock_rd_data", bus.data_o, pre[7]);
    tick();
    drive(0, 1'b1, 1'b1, 1'b0, 7, pre[7] + 32'd1);
    sample();
    check("lock_release_gnt", bus.gnt_o, 2'b01);
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, 0, '0);
    sample();
    check("lock_after", bus.gnt_o, 2'b10);
    tick();
    clear_all();
    check("rmw_mem", mem[7], pre[7] + 32'd1);

    // Reset with a read pending
    drive(0, 1'b1, 1'b0, 1'b0, 1, '0);
    cyc();
    clear_all();
    rst = 1'b1;
    sample();
    check("rst_drop_rdy", bus.rdy_o, 2'b00);
    tick();
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 1'b0, 4, '0);
    drive(1, 1'b1, 1'b0, 1'b0, 6, '0);
    sample();
    check("rst_first_gnt", bus.gnt_o, 2'b01);
    check("rst_no_late_rdy", bus.rdy_o, 2'b00);
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, 0, '0);
    cyc();
    clear_all();

    // Idle
    for (int i = 0; i < 10; i++) begin
      sample();
      check("idle_en", bram_en, 1'b0);
      check("idle_we", bram_we, 1'b0);
      check("idle_gnt", bus.gnt_o, 2'b00);
      if (i > 0) check("idle_rdy", bus.rdy_o, 2'b00);
      tick();
    end
    for (int a = 0; a < SZ; a++) check("idle_mem", mem[a], ref_mem[a]);

    // Constrained-random traffic with locks and occasional resets
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!bus.req_i[k] || last_found == k) begin
          bus.req_i[k]           = ($urandom_range(0, 2) != 0);
          bus.we_i[k]            = $urandom_range(0, 1) == 1;
          bus.addr_i[k*AW +: AW] = AW'($urandom_range(0, SZ - 1));
          bus.data_i[k*DW +: DW] = $urandom;
        end
        bus.lock_i[k] = ($urandom_range(0, 3) == 0);
      end
      rst = ($urandom_range(0, 63) == 0);
      cyc();
    end
    rst = 1'b0;
    clear_all();
    cyc();
    cyc();
    for (int a = 0; a < SZ; a++) check("final_mem", mem[a], ref_mem[a]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
